// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//   Multi-digit hexadecimal seven-segment display controller. Holds a
//   NUM_DIGITS-nibble value that is loaded over a valid/ready handshake or
//   incremented in place, and drives registered segment patterns with per
//   digit enable, blink and leading-zero blanking.
//
//   Handshake: a load is accepted on a rising clock edge where
//   load_valid && load_ready. After an accept, load_ready is low for exactly
//   one cycle (BUSY) and then returns high. The requester holds load_valid
//   and load_data stable until accepted. load_ready is decoded directly from
//   the handshake state register, so it also serves as the state observation
//   point.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   load_valid  load request, load_data valid this cycle
//   load_ready  controller can accept a load this cycle
//   load_data   new value, nibble i feeds digit i (digit 0 least significant)
//   inc         one-cycle strobe: value += 1 modulo 16^NUM_DIGITS
//   digit_en    per digit: 1 = displayed, 0 = forced blank
//   blink_en    per digit: 1 = blanked during the blink-off phase
//   lz_blank    1 = suppress leading zeros (digit 0 always shows)
//   HEX         HEX[7i+6:7i] = segments g..a of digit i (registered)
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    inc,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_blank,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int HW = 7 * NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_BUSY  = 1'b1
  } hs_state_e;

  hs_state_e     state_q, state_d;
  logic [VW-1:0] value_q, value_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [HW-1:0] hex_q, hex_d;
  logic          accept;

  // Glyph table is stored active-low (g..a); inverted for active-high boards.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return ACTIVE_LOW ? g : ~g;
  endfunction

  assign accept     = load_valid && (state_q == ST_READY);
  assign load_ready = (state_q == ST_READY);
  assign HEX        = hex_q;

  // Handshake FSM: an accept costs exactly one BUSY cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY: if (accept) state_d = ST_BUSY;
      ST_BUSY:  state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  // Value register: a load has priority over a same-edge increment.
  always_comb begin
    value_d = value_q;
    if (accept) begin
      value_d = load_data;
    end else if (inc) begin
      value_d = value_q + VW'(1);
    end
  end

  // Free-running blink divider; phase toggles each time the counter wraps.
  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Segment generation. Scanning from the most significant digit down,
  // zeros_above stays set while every nibble seen so far is zero.
  always_comb begin
    logic       zeros_above;
    logic [3:0] nib;
    logic       blank;
    hex_d       = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib   = value_q[4*i +: 4];
      blank = !digit_en[i]
           || (blink_en[i] && phase_q)
           || (lz_blank && zeros_above && (nib == 4'h0) && (i != 0));
      hex_d[7*i +: 7] = blank ? SEG_BLANK : glyph(nib);
      zeros_above = zeros_above && (nib == 4'h0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_READY;
      value_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
    end
  end

endmodule
